// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types for the RV32I ID/EX stage: ALU opcodes, forward
//               selects and the ID/EX pipeline register layout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam int c_data_w   = 32;
  localparam int c_reg_w    = 5;
  localparam int c_opcode_w = 4;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLL = 4'b0101,
    ALU_SRL = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_EQ  = 4'b1000,
    ALU_SRA = 4'b1001
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic                  valid;
    logic [c_reg_w-1:0]    rs1;
    logic [c_reg_w-1:0]    rs2;
    logic [c_reg_w-1:0]    rd;
    logic [c_data_w-1:0]   rd1;
    logic [c_data_w-1:0]   rd2;
    logic [c_data_w-1:0]   imm;
    logic [c_data_w-1:0]   pc;
    logic [c_opcode_w-1:0] alu_op;
    logic                  alu_src;
    logic                  a_pc;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } id_ex_t;

endpackage

`default_nettype wire

// File: rtl/forward_unit.sv
// ============================================================================
// Module      : forward_unit
// Description : Picks the newest producer of one EX source register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module forward_unit
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output fwd_sel_t              sel
);

  // MEM holds the younger result, so it wins over WB; x0 is never a producer.
  always_comb begin
    sel = FWD_REG;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with MEM/WB forwarding, load-use
//               stall detection and bubble insertion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_ADDR_W    = 5,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic [DATA_WIDTH-1:0]    id_rd1,
  input  logic [DATA_WIDTH-1:0]    id_rd2,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_alu_src,
  input  logic                     id_a_pc,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic                     ex_flush,
  input  logic [REG_ADDR_W-1:0]    mem_rd,
  input  logic                     mem_reg_write,
  input  logic [DATA_WIDTH-1:0]    mem_result,
  input  logic [REG_ADDR_W-1:0]    wb_rd,
  input  logic                     wb_reg_write,
  input  logic [DATA_WIDTH-1:0]    wb_result,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic                     ex_valid,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic [DATA_WIDTH-1:0]    ex_pc,
  output logic                     load_use_stall
);

  id_ex_t                r_ex;
  id_ex_t                w_next;
  logic                  w_bubble;
  logic                  w_live;
  fwd_sel_t              w_sel_a;
  fwd_sel_t              w_sel_b;
  logic [DATA_WIDTH-1:0] w_fwd_a;
  logic [DATA_WIDTH-1:0] w_fwd_b;

  // Conservative: rs2 is compared even for instructions that do not read it.
  assign load_use_stall = r_ex.valid && r_ex.mem_read && (r_ex.rd != '0) && id_valid &&
                          ((r_ex.rd == id_rs1) || (r_ex.rd == id_rs2));

  assign w_bubble = ex_flush | load_use_stall;
  assign w_live   = id_valid & ~w_bubble;

  always_comb begin
    w_next           = '0;
    w_next.rs1       = id_rs1;
    w_next.rs2       = id_rs2;
    w_next.rd        = id_rd;
    w_next.rd1       = id_rd1;
    w_next.rd2       = id_rd2;
    w_next.imm       = id_imm;
    w_next.pc        = id_pc;
    w_next.alu_op    = id_alu_op;
    w_next.alu_src   = id_alu_src;
    w_next.a_pc      = id_a_pc;
    w_next.valid     = w_live;
    w_next.reg_write = w_live & id_reg_write;
    w_next.mem_read  = w_live & id_mem_read;
    w_next.mem_write = w_live & id_mem_write;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex <= '0;
    end else begin
      r_ex <= w_next;
    end
  end

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs            (r_ex.rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (w_sel_a)
  );

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs            (r_ex.rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (w_sel_b)
  );

  always_comb begin
    w_fwd_a = r_ex.rd1;
    case (w_sel_a)
      FWD_MEM: w_fwd_a = mem_result;
      FWD_WB:  w_fwd_a = wb_result;
      default: w_fwd_a = r_ex.rd1;
    endcase
  end

  always_comb begin
    w_fwd_b = r_ex.rd2;
    case (w_sel_b)
      FWD_MEM: w_fwd_b = mem_result;
      FWD_WB:  w_fwd_b = wb_result;
      default: w_fwd_b = r_ex.rd2;
    endcase
  end

  assign SrcA          = r_ex.a_pc    ? r_ex.pc  : w_fwd_a;
  assign SrcB          = r_ex.alu_src ? r_ex.imm : w_fwd_b;
  assign ex_store_data = w_fwd_b;
  assign Operation     = r_ex.alu_op;
  assign ex_valid      = r_ex.valid;
  assign ex_reg_write  = r_ex.reg_write;
  assign ex_mem_read   = r_ex.mem_read;
  assign ex_mem_write  = r_ex.mem_write;
  assign ex_rd         = r_ex.rd;
  assign ex_pc         = r_ex.pc;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage (vector table + sequences).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rd1, id_rd2, id_imm, id_pc;
  logic [3:0]  id_alu_op;
  logic        id_alu_src, id_a_pc, id_reg_write, id_mem_read, id_mem_write;
  logic        ex_flush;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;
  logic [31:0] SrcA, SrcB, ex_store_data, ex_pc;
  logic [3:0]  Operation;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;
  logic [4:0]  ex_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc(id_pc),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_a_pc(id_a_pc),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .ex_flush(ex_flush),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ex_store_data(ex_store_data),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_pc(ex_pc),
    .load_use_stall(load_use_stall)
  );

  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, imm, pc;
    logic [3:0]  op;
    logic        alu_src, a_pc, rw, mr, mw;
    logic [4:0]  mrd;
    logic        mrw;
    logic [31:0] mres;
    logic [4:0]  wrd;
    logic        wrw;
    logic [31:0] wres;
    logic [31:0] e_srca, e_srcb, e_store;
    logic [3:0]  e_op;
    logic        e_valid, e_rw, e_mw;
    logic [4:0]  e_rd;
    logic [31:0] e_pc;
  } vec_t;

  typedef struct {
    logic [31:0] srca, srcb, store;
    logic [3:0]  op;
    logic        valid, rw, mw;
    logic [4:0]  rd;
    logic [31:0] pc;
  } exp_t;

  vec_t vecs [7];
  exp_t sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] op,
                          input logic asrc, input logic apc, input logic rw, input logic mr,
                          input logic mw);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rd1 = rd1; id_rd2 = rd2; id_imm = imm; id_pc = pc; id_alu_op = op;
    id_alu_src = asrc; id_a_pc = apc; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic set_fwd(input logic [4:0] mrd, input logic mrw, input logic [31:0] mres,
                         input logic [4:0] wrd, input logic wrw, input logic [31:0] wres);
    mem_rd = mrd; mem_reg_write = mrw; mem_result = mres;
    wb_rd = wrd; wb_reg_write = wrw; wb_result = wres;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ex_valid"}, {31'd0, ex_valid}, 32'd0);
    check({tag, " ex_reg_write"}, {31'd0, ex_reg_write}, 32'd0);
    check({tag, " ex_mem_read"}, {31'd0, ex_mem_read}, 32'd0);
    check({tag, " ex_mem_write"}, {31'd0, ex_mem_write}, 32'd0);
    check({tag, " ex_rd"}, {27'd0, ex_rd}, 32'd0);
    check({tag, " ex_pc"}, ex_pc, 32'd0);
    check({tag, " Operation"}, {28'd0, Operation}, 32'd0);
    check({tag, " SrcA"}, SrcA, 32'd0);
    check({tag, " SrcB"}, SrcB, 32'd0);
    check({tag, " store_data"}, ex_store_data, 32'd0);
    check({tag, " stall"}, {31'd0, load_use_stall}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    //        v  rs1 rs2 rd  rd1       rd2       imm       pc        op  as ap rw mr mw  mrd mrw mres         wrd wrw wres         srca          srcb          store         op  v  rw mw rd  pc
    vecs[0] = '{1, 5,  6,  10, 32'h11,   32'h22,   32'h33,   32'h40,   2, 0, 0, 1, 0, 0,  5,  1,  32'hAA,      5,  1,  32'hBB,      32'hAA,       32'h22,       32'h22,       2,  1, 1, 0, 10, 32'h40};
    vecs[1] = '{1, 0,  0,  1,  32'h0,    32'h0,    32'h44,   32'h44,   3, 0, 0, 1, 0, 0,  0,  1,  32'hFF,      0,  1,  32'hEE,      32'h0,        32'h0,        32'h0,        3,  1, 1, 0, 1,  32'h44};
    vecs[2] = '{1, 9,  7,  2,  32'h91,   32'h72,   32'h5,    32'h48,   4, 0, 0, 1, 0, 0,  8,  1,  32'h888,     7,  1,  32'h777,     32'h91,       32'h777,      32'h777,      4,  1, 1, 0, 2,  32'h48};
    vecs[3] = '{1, 12, 13, 0,  32'hC0,   32'hD0,   32'h10,   32'h4C,   2, 1, 0, 0, 0, 1,  13, 1,  32'hDDDD,    12, 1,  32'hCCCC,    32'hCCCC,     32'h10,       32'hDDDD,     2,  1, 0, 1, 0,  32'h4C};
    vecs[4] = '{1, 0,  0,  6,  32'h0,    32'h0,    32'h2000, 32'h100,  2, 1, 1, 1, 0, 0,  0,  0,  32'h0,       0,  0,  32'h0,       32'h100,      32'h2000,     32'h0,        2,  1, 1, 0, 6,  32'h100};
    vecs[5] = '{1, 14, 15, 7,  32'hE1,   32'hF2,   32'h0,    32'h104,  7, 0, 0, 1, 0, 0,  14, 0,  32'h1,       15, 1,  32'h2F,      32'hE1,       32'h2F,       32'h2F,       7,  1, 1, 0, 7,  32'h104};
    vecs[6] = '{0, 1,  2,  8,  32'hA1,   32'hA2,   32'h0,    32'h108,  9, 0, 0, 1, 0, 1,  0,  0,  32'h0,       0,  0,  32'h0,       32'hA1,       32'hA2,       32'hA2,       9,  0, 0, 0, 8,  32'h108};

    reset = 1'b1;
    ex_flush = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    tick(); tick();
    check_all_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      drive_id(vecs[i].valid, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].rd1, vecs[i].rd2,
               vecs[i].imm, vecs[i].pc, vecs[i].op, vecs[i].alu_src, vecs[i].a_pc,
               vecs[i].rw, vecs[i].mr, vecs[i].mw);
      sb.push_back('{vecs[i].e_srca, vecs[i].e_srcb, vecs[i].e_store, vecs[i].e_op,
                     vecs[i].e_valid, vecs[i].e_rw, vecs[i].e_mw, vecs[i].e_rd, vecs[i].e_pc});
      tick();
      set_fwd(vecs[i].mrd, vecs[i].mrw, vecs[i].mres, vecs[i].wrd, vecs[i].wrw, vecs[i].wres);
      #1;
      e = sb.pop_front();
      check($sformatf("v%0d SrcA", i), SrcA, e.srca);
      check($sformatf("v%0d SrcB", i), SrcB, e.srcb);
      check($sformatf("v%0d store_data", i), ex_store_data, e.store);
      check($sformatf("v%0d Operation", i), {28'd0, Operation}, {28'd0, e.op});
      check($sformatf("v%0d ex_valid", i), {31'd0, ex_valid}, {31'd0, e.valid});
      check($sformatf("v%0d ex_reg_write", i), {31'd0, ex_reg_write}, {31'd0, e.rw});
      check($sformatf("v%0d ex_mem_write", i), {31'd0, ex_mem_write}, {31'd0, e.mw});
      check($sformatf("v%0d ex_rd", i), {27'd0, ex_rd}, {27'd0, e.rd});
      check($sformatf("v%0d ex_pc", i), ex_pc, e.pc);
    end

    // Load-use: lw x3 in EX, add x4,x1,x3 in ID.
    set_fwd(0, 0, 0, 0, 0, 0);
    drive_id(1, 2, 0, 3, 32'h200, 0, 32'h8, 32'h300, 2, 1, 0, 1, 1, 0);
    tick();
    check("lu load ex_mem_read", {31'd0, ex_mem_read}, 32'd1);
    drive_id(1, 1, 3, 4, 32'h5, 32'hDEAD, 0, 32'h304, 2, 0, 0, 1, 0, 0);
    #1;
    check("lu stall N", {31'd0, load_use_stall}, 32'd1);
    tick();
    set_fwd(3, 1, 32'h208, 0, 0, 0);
    #1;
    check("lu bubble ex_valid", {31'd0, ex_valid}, 32'd0);
    check("lu bubble ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
    check("lu stall N+1", {31'd0, load_use_stall}, 32'd0);
    tick();
    set_fwd(0, 0, 0, 3, 1, 32'h1234);
    #1;
    check("lu consumer ex_valid", {31'd0, ex_valid}, 32'd1);
    check("lu consumer SrcB", SrcB, 32'h1234);
    check("lu consumer ex_rd", {27'd0, ex_rd}, 32'd4);
    check("lu stall N+2", {31'd0, load_use_stall}, 32'd0);

    // Flush and stall in the same cycle: one bubble only.
    set_fwd(0, 0, 0, 0, 0, 0);
    drive_id(1, 2, 0, 3, 32'h200, 0, 32'h8, 32'h308, 2, 1, 0, 1, 1, 0);
    tick();
    drive_id(1, 3, 5, 0, 0, 32'h55, 32'h4, 32'h200, 2, 1, 0, 0, 0, 1);
    ex_flush = 1'b1;
    #1;
    check("fs stall", {31'd0, load_use_stall}, 32'd1);
    tick();
    ex_flush = 1'b0;
    check("fs ex_valid", {31'd0, ex_valid}, 32'd0);
    check("fs ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
    check("fs ex_mem_write", {31'd0, ex_mem_write}, 32'd0);
    check("fs ex_mem_read", {31'd0, ex_mem_read}, 32'd0);
    tick();
    check("fs store ex_valid", {31'd0, ex_valid}, 32'd1);
    check("fs store ex_mem_write", {31'd0, ex_mem_write}, 32'd1);
    check("fs store ex_pc", ex_pc, 32'h200);

    // Asynchronous reset in the middle of a cycle with a valid EX entry.
    set_fwd(0, 0, 0, 3, 1, 32'h77);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async");
    #1;
    reset = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the 5-stage RV32I core. It captures decoded operands and control from ID and resolves data hazards by forwarding from the MEM and WB stages. It drives `SrcA`, `SrcB` and `Operation` straight into the ALU. It also detects load-use hazards: it requests an IF/ID stall and inserts a bubble into EX.

## Interface
Parameters:
- `DATA_WIDTH`, 32: operand/result width
- `REG_ADDR_W`, 5: register index width
- `OPCODE_LENGTH`, 4: ALU operation code width

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `id_valid`  in  1  ID holds a real instruction
- `id_rs1`, `id_rs2`, `id_rd`  in  5  register indices
- `id_rd1`, `id_rd2`  in  32  register-file read data
- `id_imm`, `id_pc`  in  32  immediate, instruction PC
- `id_alu_op`  in  4  ALU operation code
- `id_alu_src`  in  1  1 = SrcB takes immediate
- `id_a_pc`  in  1  1 = SrcA takes PC (AUIPC/JAL)
- `id_reg_write`, `id_mem_read`, `id_mem_write`  in  1  control
- `ex_flush`  in  1  squash instruction entering EX (branch taken)
- `mem_rd`  in  5, `mem_reg_write`  in  1, `mem_result`  in  32  EX/MEM forward source
- `wb_rd`  in  5, `wb_reg_write`  in  1, `wb_result`  in  32  MEM/WB forward source
- `SrcA`, `SrcB`  out  32  ALU operands
- `Operation`  out  4  ALU operation code
- `ex_store_data`  out  32  forwarded rs2 value for stores
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`  out  1  registered control
- `ex_rd`  out  5, `ex_pc`  out  32  registered fields
- `load_use_stall`  out  1  hold PC and IF/ID this cycle

## Operation
- ID/EX register loads on every rising `clk`. There is no enable: EX never stalls.
- Load-use hazard: `load_use_stall = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2)`. The check is conservative and ignores whether the instruction actually uses rs2.
- Bubble: if `ex_flush | load_use_stall`, the next state is `ex_valid=0` with all write/mem control 0. The data fields may load normally.
- `ex_flush` has priority, and a flush plus a stall in the same cycle is still one bubble.
- Forwarding is applied separately for rs1 and rs2, from the registered `ex_rs1`/`ex_rs2`:
  - MEM: used when `mem_reg_write & mem_rd!=0 & mem_rd==ex_rsN`.
  - WB: used when the same test holds for wb and MEM did not match.
  - Otherwise the registered rd1/rd2 value is used.
  - x0 is never forwarded.
- `SrcA = ex_a_pc ? ex_pc : fwdA`.
- `SrcB = ex_alu_src ? ex_imm : fwdB`.
- `ex_store_data = fwdB`, independent of `ex_alu_src`.
- `Operation = ex_alu_op`, passed through unchanged.
- The register file is write-first, so no WB-to-ID bypass is needed here.

## Timing
- Reset (async assert, sync-safe deassert): every register clears to 0. Resulting outputs:
  - `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write` = 0.
  - `ex_rd` = 0, `ex_pc` = 0.
  - `Operation` = 4'b0000.
  - `SrcA`, `SrcB`, `ex_store_data` = 0, because rs = x0 disables forwarding.
  - `load_use_stall` = 0.
- Reset asserted mid-instruction discards the EX contents immediately, without waiting for a clock edge.
- Latency from ID inputs to EX register outputs is 1 cycle.
- `SrcA`, `SrcB`, `ex_store_data` and `load_use_stall` are combinational in the same cycle from registered state plus the forward inputs.
- Stall protocol:
  - Cycle N: `load_use_stall`=1 and the upstream stages hold.
  - Cycle N+1: EX holds a bubble, the load is in MEM, and the consumer is re-presented from ID.
  - Cycle N+2: the consumer is in EX with the value forwarded from WB.
- Invalid EX entries still drive forwarding muxes, but all side-effect control is 0.

## Structure
- Package `pipe_pkg`:
  - `alu_op_t`, a 4-bit enum: AND=0000, OR=0001, ADD=0010, SUB=0011, XOR=0100, SLL=0101, SRL=0110, SLT=0111, EQ=1000, SRA=1001.
  - `fwd_sel_t` enum: FWD_REG, FWD_MEM, FWD_WB.
  - `id_ex_t` packed struct holding the pipeline register.
- Sub-module `forward_unit`: purely combinational, instantiated once per source operand. It returns a `fwd_sel_t` from the rs index and the mem/wb rd and reg_write inputs.
- Top level holds the register, hazard detect, and output muxes.

## Test plan
- Reset mid-stream with `ex_valid`=1 -> all outputs 0 immediately, before any clk edge; `Operation`=0000.
- EX rs1=5, `mem_rd`=5 `mem_reg_write`=1 `mem_result`=0xAA, `wb_rd`=5 `wb_result`=0xBB -> `SrcA`=0xAA (MEM priority).
- `mem_rd`=0 `mem_reg_write`=1 `mem_result`=0xFF, ex_rs1=0, `ex_rd1`=0 -> `SrcA`=0 (x0 not forwarded).
- Load x3 in EX, ID `add` using rs2=3 -> `load_use_stall`=1 for exactly one cycle; next cycle `ex_valid`=0; the `add` reaches EX one cycle later with `SrcB`=`wb_result`.
- `ex_flush`=1 and `load_use_stall`=1 together -> a single bubble; next `ex_reg_write`=0 and `ex_mem_write`=0.
- AUIPC with `id_pc`=0x100, `id_imm`=0x2000, `id_a_pc`=1 `id_alu_src`=1 `id_alu_op`=ADD -> `SrcA`=0x100, `SrcB`=0x2000, `Operation`=0010.
